fifo_flagged: RTL and testbench

Parametrised synchronous FIFO, successor to the UART byte FIFO, sitting between the Wishbone register interface and the UART TX/RX engines. It uses all 2^FIFO_DEPTH entries via extended pointers and adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush. It has an asynchronous active-low reset. Read data is show-ahead: the head entry is always presented on the output.

---
 rtl/fifo_flagged.sv | 87 ++++++++
 tb/tb_fifo_flagged.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// Show-ahead synchronous FIFO with extended pointers, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module fifo_flagged #(
    parameter int FIFO_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n_w,
    input  logic [FIFO_WIDTH-1:0] i_data_w,
    input  logic                  i_write_w,
    input  logic                  i_read_w,
    input  logic                  i_flush_w,
    input  logic                  i_clear_err_w,
    output logic [FIFO_WIDTH-1:0] o_data_w,
    output logic                  o_full_w,
    output logic                  o_empty_w,
    output logic                  o_almost_full_w,
    output logic                  o_almost_empty_w,
    output logic [FIFO_DEPTH:0]   o_fill_w,
    output logic                  o_overflow_w,
    output logic                  o_underflow_w
);
    localparam int ENTRIES = 1 << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0] PTR_ONE = {{FIFO_DEPTH{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH:0] AF_LVL  = ALMOST_FULL_LEVEL[FIFO_DEPTH:0];
    localparam logic [FIFO_DEPTH:0] AE_LVL  = ALMOST_EMPTY_LEVEL[FIFO_DEPTH:0];

    logic [FIFO_WIDTH-1:0] mem [ENTRIES];
    logic [FIFO_DEPTH:0]   wr_ptr_reg;
    logic [FIFO_DEPTH:0]   rd_ptr_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;
    logic push_drop;
    logic pop_drop;

    assign full  = (wr_ptr_reg[FIFO_DEPTH] != rd_ptr_reg[FIFO_DEPTH]) &&
                   (wr_ptr_reg[FIFO_DEPTH-1:0] == rd_ptr_reg[FIFO_DEPTH-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // A write into a full FIFO still goes through when a pop frees the slot in the same edge.
    assign push_ok   = i_write_w && (!full || (i_read_w && !empty));
    assign pop_ok    = i_read_w && !empty;
    assign push_drop = i_write_w && !push_ok && !i_flush_w;
    assign pop_drop  = i_read_w && !pop_ok && !i_flush_w;

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_flush_w) begin
            mem[wr_ptr_reg[FIFO_DEPTH-1:0]] <= i_data_w;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n_w) begin
        if (!i_reset_n_w) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (i_flush_w) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            // Set beats clear when both happen in the same cycle.
            overflow_reg  <= push_drop || (overflow_reg && !i_clear_err_w);
            underflow_reg <= pop_drop || (underflow_reg && !i_clear_err_w);
        end
    end

    assign o_data_w         = mem[rd_ptr_reg[FIFO_DEPTH-1:0]];
    assign o_fill_w         = wr_ptr_reg - rd_ptr_reg;
    assign o_full_w         = full;
    assign o_empty_w        = empty;
    assign o_almost_full_w  = (o_fill_w >= AF_LVL);
    assign o_almost_empty_w = (o_fill_w <= AE_LVL);
    assign o_overflow_w     = overflow_reg;
    assign o_underflow_w    = underflow_reg;
endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_fifo_flagged;
    logic       i_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       fl = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] dout;
    logic       full, empty, afull, aempty, ovf, udf;
    logic [2:0] fill;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_flagged #(
        .FIFO_WIDTH(8), .FIFO_DEPTH(2), .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)
    ) dut (
        .i_clk(i_clk), .i_reset_n_w(rst_n), .i_data_w(din), .i_write_w(wr),
        .i_read_w(rd), .i_flush_w(fl), .i_clear_err_w(clr), .o_data_w(dout),
        .o_full_w(full), .o_empty_w(empty), .o_almost_full_w(afull),
        .o_almost_empty_w(aempty), .o_fill_w(fill), .o_overflow_w(ovf),
        .o_underflow_w(udf)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: contents as a queue, flags as plain bits.
    logic [7:0] q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    always @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit do_push, do_pop, set_o, set_u;
            int n;
            n = q.size();
            do_push = 1'b0; do_pop = 1'b0; set_o = 1'b0; set_u = 1'b0;
            if (!fl) begin
                do_pop  = rd && (n > 0);
                do_push = wr && ((n < 4) || do_pop);
                set_o   = wr && !do_push;
                set_u   = rd && !do_pop;
            end
            if (fl) q.delete();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(din);
            m_ovf = set_o || (m_ovf && !clr);
            m_udf = set_u || (m_udf && !clr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge i_clk) begin
        int n;
        n = q.size();
        chk("model_fill",   int'(fill),   n);
        chk("model_empty",  int'(empty),  int'(n == 0));
        chk("model_full",   int'(full),   int'(n == 4));
        chk("model_afull",  int'(afull),  int'(n >= 3));
        chk("model_aempty", int'(aempty), int'(n <= 1));
        chk("model_ovf",    int'(ovf),    int'(m_ovf));
        chk("model_udf",    int'(udf),    int'(m_udf));
        if (n > 0) chk("model_head", int'(dout), int'(q[0]));
    end

    // Apply one cycle of inputs; returns 2 time units after the edge with inputs idled.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit f, input bit c);
        wr = w; rd = r; din = d; fl = f; clr = c;
        @(posedge i_clk);
        #1;
        wr = 1'b0; rd = 1'b0; fl = 1'b0; clr = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] pat [4];
        int pw;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        #12;
        chk("rst_fill", int'(fill), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_aempty", int'(aempty), 1);
        chk("rst_flags", int'({full, afull, ovf, udf}), 0);
        @(negedge i_clk);
        rst_n = 1'b1;

        // Fill and drain
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, pat[i], 0, 0);
            $display("push 0x%0h fill=%0d afull=%0b aempty=%0b full=%0b", pat[i], fill, afull, aempty, full);
            chk("fill_step", int'(fill), i + 1);
            chk("fill_afull", int'(afull), int'(i >= 2));
            chk("fill_aempty", int'(aempty), int'(i == 0));
        end
        chk("fill_full", int'(full), 1);
        chk("fill_head", int'(dout), 8'h11);

        // Overflow and clear
        cyc(1, 0, 8'h55, 0, 0);
        $display("overflow push fill=%0d ovf=%0b head=0x%0h", fill, ovf, dout);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_fill", int'(fill), 4);
        chk("ovf_head", int'(dout), 8'h11);
        cyc(0, 0, 8'h00, 0, 1);
        chk("ovf_clear", int'(ovf), 0);

        // Simultaneous read/write while full
        cyc(1, 1, 8'hAA, 0, 0);
        $display("full rd+wr fill=%0d head=0x%0h ovf=%0b", fill, dout, ovf);
        chk("rw_full_fill", int'(fill), 4);
        chk("rw_full_head", int'(dout), 8'h22);
        chk("rw_full_ovf", int'(ovf), 0);

        cyc(0, 1, 8'h00, 0, 0); chk("pop_head1", int'(dout), 8'h33);
        cyc(0, 1, 8'h00, 0, 0); chk("pop_head2", int'(dout), 8'h44);
        cyc(0, 1, 8'h00, 0, 0); chk("pop_head3", int'(dout), 8'hAA);
        cyc(0, 1, 8'h00, 0, 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_flags", int'({ovf, udf}), 0);

        // Simultaneous read/write while empty
        cyc(1, 1, 8'hBB, 0, 0);
        $display("empty rd+wr fill=%0d head=0x%0h udf=%0b", fill, dout, udf);
        chk("rw_empty_fill", int'(fill), 1);
        chk("rw_empty_head", int'(dout), 8'hBB);
        chk("rw_empty_udf", int'(udf), 1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("udf_clear", int'(udf), 0);

        // Wrap-around at fill 2
        cyc(1, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 1, 8'(i), 0, 0);
            $display("wrap push/pop 0x%0h fill=%0d head=0x%0h", i, fill, dout);
        end
        chk("wrap_fill", int'(fill), 2);
        chk("wrap_head", int'(dout), 8'h13);
        chk("wrap_flags", int'({ovf, udf}), 0);

        // Flush precedence with overflow already set
        cyc(1, 0, 8'h21, 0, 0);
        cyc(1, 0, 8'h22, 0, 0);
        cyc(1, 0, 8'h23, 0, 0);
        cyc(0, 1, 8'h00, 0, 0);
        chk("pre_flush_fill", int'(fill), 3);
        chk("pre_flush_ovf", int'(ovf), 1);
        cyc(1, 1, 8'h99, 1, 0);
        $display("flush fill=%0d empty=%0b ovf=%0b udf=%0b", fill, empty, ovf, udf);
        chk("flush_fill", int'(fill), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_ovf", int'(ovf), 1);
        chk("flush_udf", int'(udf), 0);
        cyc(1, 0, 8'h77, 0, 0);
        chk("post_flush_head", int'(dout), 8'h77);
        cyc(0, 0, 8'h00, 0, 1);

        // Randomized phase with alternating write bias
        for (int i = 0; i < 400; i++) begin
            bit w, r, f, c;
            logic [7:0] d;
            pw = ((i / 40) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(0, 99) < pw);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 31) == 0);
            c = ($urandom_range(0, 15) == 0);
            d = 8'($urandom);
            cyc(w, r, d, f, c);
            $display("rand %0d w=%0b r=%0b f=%0b c=%0b d=0x%0h fill=%0d ovf=%0b udf=%0b", i, w, r, f, c, d, fill, ovf, udf);
        end

        // Async reset between edges with fill 3 and overflow set
        cyc(0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
        cyc(0, 1, 8'h00, 0, 0);
        chk("pre_rst_fill", int'(fill), 3);
        chk("pre_rst_ovf", int'(ovf), 1);
        #1 rst_n = 1'b0;
        #1;
        $display("async reset fill=%0d empty=%0b ovf=%0b", fill, empty, ovf);
        chk("arst_fill", int'(fill), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_ovf", int'(ovf), 0);
        #2 rst_n = 1'b1;
        cyc(1, 0, 8'h5A, 0, 0);
        chk("post_rst_fill", int'(fill), 1);
        chk("post_rst_head", int'(dout), 8'h5A);
        @(negedge i_clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
